// File: rtl/bullcow_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bullcow_pkg                                                  |
// | Description : Shared state encoding and winner codes for bullcow_engine.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package bullcow_pkg;

    typedef enum logic [2:0] {
        J1_SETUP = 3'd0,
        J2_SETUP = 3'd1,
        J1_GUESS = 3'd2,
        J2_GUESS = 3'd3,
        END_GAME = 3'd7
    } state_t;

    localparam logic [1:0] c_WIN_NONE = 2'd0;
    localparam logic [1:0] c_WIN_J1   = 2'd1;
    localparam logic [1:0] c_WIN_J2   = 2'd2;
    localparam logic [1:0] c_WIN_DRAW = 2'd3;

endpackage
`default_nettype wire

// File: rtl/bullcow_scorer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bullcow_scorer                                               |
// | Description : Combinational entry validation and bulls/cows scoring.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bullcow_scorer #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int DIGIT_MAX  = 9
) (
    input  logic [NUM_DIGITS*DIGIT_W-1:0]      guess,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]      secret,
    output logic                               valid,
    output logic [$clog2(NUM_DIGITS+1)-1:0]    bulls,
    output logic [$clog2(NUM_DIGITS+1)-1:0]    cows
);

    localparam int                 c_CNT_W     = $clog2(NUM_DIGITS + 1);
    localparam logic [DIGIT_W-1:0] c_DIGIT_MAX = DIGIT_W'(DIGIT_MAX);

    logic w_hit;

    always_comb begin
        valid = 1'b1;
        bulls = '0;
        cows  = '0;
        w_hit = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (guess[i*DIGIT_W +: DIGIT_W] > c_DIGIT_MAX)
                valid = 1'b0;
            for (int j = i + 1; j < NUM_DIGITS; j++) begin
                if (guess[i*DIGIT_W +: DIGIT_W] == guess[j*DIGIT_W +: DIGIT_W])
                    valid = 1'b0;
            end
            if (guess[i*DIGIT_W +: DIGIT_W] == secret[i*DIGIT_W +: DIGIT_W])
                bulls = bulls + c_CNT_W'(1);
            // A guess digit counts as a cow once, wherever it sits in the secret
            w_hit = 1'b0;
            for (int j = 0; j < NUM_DIGITS; j++) begin
                if (j != i && guess[i*DIGIT_W +: DIGIT_W] == secret[j*DIGIT_W +: DIGIT_W])
                    w_hit = 1'b1;
            end
            if (w_hit)
                cows = cows + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/bullcow_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bullcow_engine                                               |
// | Description : Two-player Bulls & Cows game controller with win counters.   |
// |               Optional draw after MAX_TRIES guesses: BULLCOW_DRAW_EN.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bullcow_engine #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int DIGIT_MAX  = 9,
    parameter int SCORE_W    = 8,
    parameter int MAX_TRIES  = 10
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               enter,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]      digits,
    output logic [2:0]                         state,
    output logic [$clog2(NUM_DIGITS+1)-1:0]    bulls,
    output logic [$clog2(NUM_DIGITS+1)-1:0]    cows,
    output logic                               result_valid,
    output logic                               invalid,
    output logic [1:0]                         winner,
    output logic [SCORE_W-1:0]                 points_j1,
    output logic [SCORE_W-1:0]                 points_j2
);

    import bullcow_pkg::*;

    localparam int                 c_CNT_W   = $clog2(NUM_DIGITS + 1);
    localparam logic [c_CNT_W-1:0] c_ALL_HIT = c_CNT_W'(NUM_DIGITS);

    state_t                          r_state, w_state_next;
    logic [NUM_DIGITS*DIGIT_W-1:0]   r_secret_j1, r_secret_j2, w_secret_sel;
    logic [c_CNT_W-1:0]              r_bulls, r_cows, w_bulls, w_cows;
    logic                            r_result_valid, r_invalid, r_enter_q;
    logic [1:0]                      r_winner;
    logic [SCORE_W-1:0]              r_points_j1, r_points_j2;
    logic                            w_submit, w_valid;
    logic                            w_store_j1, w_store_j2, w_score, w_invalid;
    logic                            w_win_j1, w_win_j2, w_draw, w_clear;

`ifdef BULLCOW_DRAW_EN
    localparam int                   c_TRIES_W   = $clog2(MAX_TRIES + 1);
    localparam logic [c_TRIES_W-1:0] c_MAX_TRIES = c_TRIES_W'(MAX_TRIES);
    logic [c_TRIES_W-1:0]            r_tries_j1, r_tries_j2;
`else
    logic w_unused_max_tries;
    assign w_unused_max_tries = ^MAX_TRIES;
`endif

    assign w_submit     = enter & ~r_enter_q;
    // Each guess is scored against the opponent's secret
    assign w_secret_sel = (r_state == J1_GUESS) ? r_secret_j2 : r_secret_j1;

    bullcow_scorer #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIGIT_W    (DIGIT_W),
        .DIGIT_MAX  (DIGIT_MAX)
    ) u_scorer (
        .guess  (digits),
        .secret (w_secret_sel),
        .valid  (w_valid),
        .bulls  (w_bulls),
        .cows   (w_cows)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= J1_SETUP;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_store_j1   = 1'b0;
        w_store_j2   = 1'b0;
        w_score      = 1'b0;
        w_invalid    = 1'b0;
        w_win_j1     = 1'b0;
        w_win_j2     = 1'b0;
        w_draw       = 1'b0;
        w_clear      = 1'b0;
        if (w_submit) begin
            case (r_state)
                J1_SETUP: begin
                    if (w_valid) begin
                        w_store_j1   = 1'b1;
                        w_state_next = J2_SETUP;
                    end else begin
                        w_invalid    = 1'b1;
                    end
                end
                J2_SETUP: begin
                    if (w_valid) begin
                        w_store_j2   = 1'b1;
                        w_state_next = J1_GUESS;
                    end else begin
                        w_invalid    = 1'b1;
                    end
                end
                J1_GUESS: begin
                    if (!w_valid) begin
                        w_invalid    = 1'b1;
                    end else begin
                        w_score = 1'b1;
                        if (w_bulls == c_ALL_HIT) begin
                            w_win_j1     = 1'b1;
                            w_state_next = END_GAME;
                        end else begin
                            w_state_next = J2_GUESS;
                        end
                    end
                end
                J2_GUESS: begin
                    if (!w_valid) begin
                        w_invalid    = 1'b1;
                    end else begin
                        w_score = 1'b1;
                        if (w_bulls == c_ALL_HIT) begin
                            w_win_j2     = 1'b1;
                            w_state_next = END_GAME;
`ifdef BULLCOW_DRAW_EN
                        end else if (r_tries_j1 == c_MAX_TRIES &&
                                     r_tries_j2 == c_MAX_TRIES - c_TRIES_W'(1)) begin
                            w_draw       = 1'b1;
                            w_state_next = END_GAME;
`endif
                        end else begin
                            w_state_next = J1_GUESS;
                        end
                    end
                end
                END_GAME: begin
                    w_clear      = 1'b1;
                    w_state_next = J1_SETUP;
                end
                default: w_state_next = J1_SETUP;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_enter_q      <= 1'b0;
            r_secret_j1    <= '0;
            r_secret_j2    <= '0;
            r_bulls        <= '0;
            r_cows         <= '0;
            r_result_valid <= 1'b0;
            r_invalid      <= 1'b0;
            r_winner       <= c_WIN_NONE;
            r_points_j1    <= '0;
            r_points_j2    <= '0;
        end else begin
            r_enter_q      <= enter;
            r_result_valid <= w_score;
            r_invalid      <= w_invalid;
            if (w_store_j1) r_secret_j1 <= digits;
            if (w_store_j2) r_secret_j2 <= digits;
            if (w_score) begin
                r_bulls <= w_bulls;
                r_cows  <= w_cows;
            end
            if (w_win_j1) begin
                r_winner <= c_WIN_J1;
                if (r_points_j1 != {SCORE_W{1'b1}})
                    r_points_j1 <= r_points_j1 + SCORE_W'(1);
            end
            if (w_win_j2) begin
                r_winner <= c_WIN_J2;
                if (r_points_j2 != {SCORE_W{1'b1}})
                    r_points_j2 <= r_points_j2 + SCORE_W'(1);
            end
            if (w_draw) r_winner <= c_WIN_DRAW;
            if (w_clear) begin
                r_secret_j1 <= '0;
                r_secret_j2 <= '0;
                r_bulls     <= '0;
                r_cows      <= '0;
                r_winner    <= c_WIN_NONE;
            end
        end
    end

`ifdef BULLCOW_DRAW_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tries_j1 <= '0;
            r_tries_j2 <= '0;
        end else if (w_clear) begin
            r_tries_j1 <= '0;
            r_tries_j2 <= '0;
        end else if (w_score) begin
            if (r_state == J1_GUESS && r_tries_j1 != c_MAX_TRIES)
                r_tries_j1 <= r_tries_j1 + c_TRIES_W'(1);
            if (r_state == J2_GUESS && r_tries_j2 != c_MAX_TRIES)
                r_tries_j2 <= r_tries_j2 + c_TRIES_W'(1);
        end
    end
`endif

    assign state        = r_state;
    assign bulls        = r_bulls;
    assign cows         = r_cows;
    assign result_valid = r_result_valid;
    assign invalid      = r_invalid;
    assign winner       = r_winner;
    assign points_j1    = r_points_j1;
    assign points_j2    = r_points_j2;

endmodule
`default_nettype wire

// File: tb/tb_bullcow_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bullcow_engine                                            |
// | Description : Directed self-checking bench for bullcow_engine.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bullcow_engine;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enter = 1'b0;
    logic [15:0] digits = 16'h0;
    logic [2:0]  state;
    logic [2:0]  bulls, cows;
    logic        result_valid, invalid;
    logic [1:0]  winner;
    logic [1:0]  points_j1, points_j2;

    int n_pass  = 0;
    int n_total = 0;

    bullcow_engine #(
        .NUM_DIGITS (4),
        .DIGIT_W    (4),
        .DIGIT_MAX  (9),
        .SCORE_W    (2),
        .MAX_TRIES  (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enter        (enter),
        .digits       (digits),
        .state        (state),
        .bulls        (bulls),
        .cows         (cows),
        .result_valid (result_valid),
        .invalid      (invalid),
        .winner       (winner),
        .points_j1    (points_j1),
        .points_j2    (points_j2)
    );

    always #5 clock = ~clock;

    // One press/release; returns on the negedge after the sampling posedge
    task automatic press(input logic [15:0] v);
        @(negedge clock);
        digits = v;
        enter  = 1'b1;
        @(negedge clock);
        enter  = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_total++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
        n_total++; if ({bulls, cows} !== 6'd0) $display("FAIL reset_bc: got %0d/%0d want 0/0", bulls, cows); else n_pass++;
        n_total++; if ({result_valid, invalid, winner} !== 4'd0) $display("FAIL reset_flags: got rv=%b inv=%b win=%0d want 0", result_valid, invalid, winner); else n_pass++;
        n_total++; if ({points_j1, points_j2} !== 4'd0) $display("FAIL reset_points: got %0d/%0d want 0/0", points_j1, points_j2); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_setup_invalid;
        press(16'h1123);
        n_total++; if (invalid !== 1'b1) $display("FAIL dup_invalid: got %b want 1", invalid); else n_pass++;
        n_total++; if (state !== 3'd0) $display("FAIL dup_state: got %0d want 0", state); else n_pass++;
        @(negedge clock);
        n_total++; if (invalid !== 1'b0) $display("FAIL invalid_pulse: got %b want 0", invalid); else n_pass++;
        press(16'h1234);
        n_total++; if (state !== 3'd1) $display("FAIL setup_j1: got %0d want 1", state); else n_pass++;
    endtask

    task automatic test_guess;
        press(16'h5678);
        n_total++; if (state !== 3'd2) $display("FAIL setup_j2: got %0d want 2", state); else n_pass++;
        press(16'h5587);
        n_total++; if (invalid !== 1'b1 || state !== 3'd2) $display("FAIL guess_invalid: got inv=%b st=%0d want 1/2", invalid, state); else n_pass++;
        press(16'h5687);
        n_total++; if (bulls !== 3'd2 || cows !== 3'd2) $display("FAIL guess_score: got %0d/%0d want 2/2", bulls, cows); else n_pass++;
        n_total++; if (result_valid !== 1'b1) $display("FAIL rv_pulse: got %b want 1", result_valid); else n_pass++;
        n_total++; if (state !== 3'd3) $display("FAIL guess_state: got %0d want 3", state); else n_pass++;
        @(negedge clock);
        n_total++; if (result_valid !== 1'b0 || bulls !== 3'd2) $display("FAIL rv_hold: got rv=%b bulls=%0d want 0/2", result_valid, bulls); else n_pass++;
    endtask

    task automatic test_win;
        press(16'h1234);
        n_total++; if (bulls !== 3'd4 || cows !== 3'd0) $display("FAIL win_score: got %0d/%0d want 4/0", bulls, cows); else n_pass++;
        n_total++; if (winner !== 2'd2 || points_j2 !== 2'd1 || state !== 3'd7) $display("FAIL win_j2: got w=%0d p2=%0d st=%0d want 2/1/7", winner, points_j2, state); else n_pass++;
        press(16'h0000);
        n_total++; if (state !== 3'd0 || points_j2 !== 2'd1) $display("FAIL end_exit: got st=%0d p2=%0d want 0/1", state, points_j2); else n_pass++;
        n_total++; if (winner !== 2'd0 || bulls !== 3'd0) $display("FAIL end_clear: got w=%0d bulls=%0d want 0/0", winner, bulls); else n_pass++;
    endtask

    task automatic test_hold;
        @(negedge clock);
        digits = 16'h1234;
        enter  = 1'b1;
        repeat (20) @(negedge clock);
        n_total++; if (state !== 3'd1) $display("FAIL hold_once: got %0d want 1", state); else n_pass++;
        enter = 1'b0;
        press(16'h12A4);
        n_total++; if (invalid !== 1'b1 || state !== 3'd1) $display("FAIL range_invalid: got inv=%b st=%0d want 1/1", invalid, state); else n_pass++;
        press(16'h9876);
        n_total++; if (state !== 3'd2) $display("FAIL hold_setup_j2: got %0d want 2", state); else n_pass++;
    endtask

    task automatic test_reset_mid_game;
        press(16'h9867);
        n_total++; if (state !== 3'd3 || bulls !== 3'd2 || cows !== 3'd2) $display("FAIL pre_reset: got st=%0d b=%0d c=%0d want 3/2/2", state, bulls, cows); else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_total++; if (state !== 3'd0 || bulls !== 3'd0 || cows !== 3'd0) $display("FAIL async_reset: got st=%0d b=%0d c=%0d want 0", state, bulls, cows); else n_pass++;
        n_total++; if (points_j2 !== 2'd0 || winner !== 2'd0) $display("FAIL reset_points_mid: got p2=%0d w=%0d want 0/0", points_j2, winner); else n_pass++;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_draw;
        press(16'h1234);
        press(16'h5678);
        press(16'h1234);
        press(16'h5678);
        press(16'h1234);
        n_total++; if (state !== 3'd3 || winner !== 2'd0 || bulls !== 3'd0) $display("FAIL draw_pre: got st=%0d w=%0d b=%0d want 3/0/0", state, winner, bulls); else n_pass++;
        press(16'h5678);
`ifdef BULLCOW_DRAW_EN
        n_total++; if (winner !== 2'd3 || state !== 3'd7) $display("FAIL draw: got w=%0d st=%0d want 3/7", winner, state); else n_pass++;
        n_total++; if ({points_j1, points_j2} !== 4'd0) $display("FAIL draw_points: got %0d/%0d want 0/0", points_j1, points_j2); else n_pass++;
        press(16'h0000);
        n_total++; if (state !== 3'd0 || winner !== 2'd0) $display("FAIL draw_exit: got st=%0d w=%0d want 0/0", state, winner); else n_pass++;
`else
        n_total++; if (winner !== 2'd0 || state !== 3'd2) $display("FAIL no_draw: got w=%0d st=%0d want 0/2", winner, state); else n_pass++;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
`endif
    endtask

    task automatic test_saturate;
        for (int g = 0; g < 4; g++) begin
            press(16'h1234);
            press(16'h5678);
            press(16'h5678);
            press(16'h0000);
        end
        n_total++; if (points_j1 !== 2'd3 || points_j2 !== 2'd0) $display("FAIL saturate: got %0d/%0d want 3/0", points_j1, points_j2); else n_pass++;
        n_total++; if (state !== 3'd0) $display("FAIL saturate_state: got %0d want 0", state); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_setup_invalid;
        test_guess;
        test_win;
        test_hold;
        test_reset_mid_game;
        test_draw;
        test_saturate;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bullcow_engine.md
BULLCOW_ENGINE -- requirements
Module: bullcow_engine

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: digits per secret/guess, legal range 2..8.
REQ-002 SHALL have parameter DIGIT_W, default 4: bits per digit.
REQ-003 SHALL have parameter DIGIT_MAX, default 9: largest legal digit value.
REQ-004 SHALL have parameter SCORE_W, default 8: width of each win counter.
REQ-005 SHALL have parameter MAX_TRIES, default 10: guesses per player before a draw (used only with BULLCOW_DRAW_EN).
REQ-006 SHALL have port clock, input, 1 bit: clock, rising edge; reset is reset, asynchronous, active-high.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-008 SHALL have port enter, input, 1 bit: level-sensitive submit button, already synchronised.
REQ-009 SHALL have port digits, input, NUM_DIGITS*DIGIT_W bits: digit i at bits [i*DIGIT_W +: DIGIT_W].
REQ-010 SHALL have port state, output, 3 bits: current FSM state encoding.
REQ-011 SHALL have port bulls and port cows, output, each $clog2(NUM_DIGITS+1) bits: last guess result.
REQ-012 SHALL have port result_valid, output, 1 bit: one-cycle pulse when bulls/cows update.
REQ-013 SHALL have port invalid, output, 1 bit: one-cycle pulse on rejected entry.
REQ-014 SHALL have port winner, output, 2 bits: 0 none, 1 J1, 2 J2, 3 draw; held in END_GAME.
REQ-015 SHALL have ports points_j1 and points_j2, output, SCORE_W bits each: win counters.

Function
REQ-016 SHALL detect a submit as enter=1 while the registered previous enter=0; one action per press; held enter SHALL NOT repeat.
REQ-017 SHALL treat an entry as valid iff all digits pairwise distinct and every digit <= DIGIT_MAX.
REQ-018 SHALL implement states J1_SETUP, J2_SETUP, J1_GUESS, J2_GUESS, END_GAME; all transitions occur only on a submit.
REQ-019 J1_SETUP: valid -> store J1 secret, go J2_SETUP; invalid -> pulse invalid, stay.
REQ-020 J2_SETUP: valid -> store J2 secret, go J1_GUESS; invalid -> pulse invalid, stay.
REQ-021 J1_GUESS: valid -> score against J2 secret; bulls==NUM_DIGITS -> increment points_j1, winner=1, go END_GAME; else go J2_GUESS; invalid -> pulse invalid, stay.
REQ-022 J2_GUESS: symmetric against J1 secret, increments points_j2, winner=2, else go J1_GUESS.
REQ-023 bulls = count of positions equal; cows = count of guess digits present in secret at a different position.
REQ-024 bulls, cows, result_valid SHALL be registered and update on the same clock edge that samples the submit (latency 1 cycle from enter rising); bulls/cows hold until next valid guess.
REQ-025 END_GAME: submit -> clear secrets, bulls, cows, winner; go J1_SETUP; points retained.
REQ-026 Win counters SHALL saturate at 2^SCORE_W-1.
REQ-027 Secrets SHALL never be output.

Reset
REQ-028 Reset SHALL force state=J1_SETUP, secrets, bulls, cows, winner, points_j1, points_j2, tries, previous-enter register to 0; result_valid and invalid to 0.
REQ-029 Reset mid-game SHALL discard the game in progress with no score change.

Configuration
REQ-030 With BULLCOW_DRAW_EN defined: per-player try counters count valid guesses; when J2's MAX_TRIES-th guess misses (J1 already at MAX_TRIES), SHALL set winner=3, go END_GAME, no points change.
REQ-031 Without BULLCOW_DRAW_EN: no try counters exist; guessing alternates indefinitely; winner never 3.

Structure
REQ-032 Package bullcow_pkg SHALL hold state_t enum (J1_SETUP=0, J2_SETUP=1, J1_GUESS=2, J2_GUESS=3, END_GAME=7) and winner encoding constants.
REQ-033 Combinational sub-module bullcow_scorer SHALL compute valid, bulls, cows from guess and secret, parametrised identically.

Verification (defaults, digits shown digit3..digit0 hex)
REQ-034 Secret entry 0x1123 in J1_SETUP -> invalid pulse, state stays 0; then 0x1234 -> state 1.
REQ-035 J1=0x1234, J2=0x5678; J1 guesses 0x5687 -> bulls=2, cows=2, result_valid one cycle, state=3.
REQ-036 J2 guesses 0x1234 -> bulls=4, winner=2, points_j2=1, state=7; submit -> state=0, points_j2 still 1.
REQ-037 Hold enter high 20 cycles in J1_SETUP with valid digits -> exactly one transition; entry 0x12A4 -> invalid.
REQ-038 Assert reset during J2_GUESS -> all outputs 0, state=0; with BULLCOW_DRAW_EN, MAX_TRIES=2, four missing guesses -> winner=3, points unchanged.
